// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Moore control FSM for the shared multicycle MIPS datapath (one memory, one
// ALU, IR/MDR/A/B/ALUOut registers). It decodes the opcode and drives every
// datapath mux select and write enable for the current state.
//
// The branch decision is folded in here: PcEn = PcWrite | (PcWriteCond & zero).
// The datapath therefore needs no separate branch AND gate.
//
// Optional build macro: MEM_WAIT_EN
//   When it is defined, FETCH, MEMRD and MEMWR hold until mem_ready = 1.
//   When it is undefined, mem_ready is ignored and every memory state lasts
//   exactly one cycle.
//
// Memory handshake (MEM_WAIT_EN only):
//   - A memory state keeps its strobes asserted on every cycle it is held.
//   - The memory raises mem_ready for exactly the cycle in which the access
//     completes.
//   - The FSM advances on the rising edge where mem_ready = 1.
//   - Strobes that commit architectural state assert only in that cycle:
//     PcEn and IRWrite in FETCH, instr_done in MEMWR.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; forces FETCH, gates all outputs to 0
//   opcode     in   IR[31:26]; sampled only in DECODE and MEMADR
//   zero       in   ALU zero flag; used in BRANCH
//   mem_ready  in   memory completion (MEM_WAIT_EN only)
//   PcEn .. PCSource  out  datapath control strobes and selects
//   instr_done out  pulse on the last cycle of each instruction
//   illegal_op out  pulse in DECODE for an unrecognised opcode
//   state      out  current state, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PcEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_done;

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    // mem_ready is not used in this build; every memory access takes one cycle.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                state_d = mem_done ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                state_d = mem_done ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                state_d = S_ALUWB;
            end
            S_ADDIEX: begin
                state_d = S_ADDIWB;
            end
            // ALUWB, BRANCH, ADDIWB, JUMP and the unused encodings 12..15
            // all return to FETCH.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output logic. Reset gates every output so that no FETCH strobe can
    // reach the datapath while reset is held, even though the state is FETCH.
    logic pc_write;
    logic pc_write_cond;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    IRWrite  = mem_done;
                    ALUSrcB  = 2'b01;
                    pc_write = mem_done;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                        default:                                       illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_done;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ALUOp         = 2'b01;
                    PCSource      = 2'b01;
                    pc_write_cond = 1'b1;
                    instr_done    = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCSource   = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign PcEn  = pc_write | (pc_write_cond & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mips_multicycle_ctrl.
//
// The driver issues one instruction at a time, starting while the DUT is in
// FETCH. For every cycle of that instruction it pushes the expected packed
// output vector into exp_q. The vectors come from the per-state control table
// and the per-opcode state sequences, both written out by hand.
//
// A monitor runs on the falling edge. It pops one vector per cycle whenever
// the queue holds any, and compares it with the DUT outputs. Checks that must
// happen between clock edges, such as the asynchronous reset abort, are made
// directly by the driver.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int VW = 21;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PcEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    logic [VW-1:0] exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PcEn       (PcEn),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    // Packed vector order:
    // {PcEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    //  ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state}
    logic [VW-1:0] act_vec;
    assign act_vec = {PcEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state};

    // Hand-written control table, one entry per state.
    function automatic logic [VW-1:0] exp_out(input int st, input logic z, input logic rdy,
                                              input logic ill);
        logic       pcen, iord, mr, mw, irw, rd, m2r, rw, srca, done;
        logic [1:0] srcb, aluop, pcs;
        logic [3:0] s4;
        {pcen, iord, mr, mw, irw, rd, m2r, rw, srca, done} = '0;
        srcb  = 2'b00;
        aluop = 2'b00;
        pcs   = 2'b00;
        s4    = st[3:0];
        case (st)
            0:  begin mr = 1; irw = rdy; srcb = 2'b01; pcen = rdy; end
            1:  begin srcb = 2'b11; end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = rdy; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin srca = 1; aluop = 2'b01; pcs = 2'b01; pcen = z; done = 1; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: begin rw = 1; done = 1; end
            11: begin pcs = 2'b10; pcen = 1; done = 1; end
            default: begin end
        endcase
        return {pcen, iord, mr, mw, irw, rd, m2r, rw, srca, srcb, aluop, pcs, done,
                (st == 1) ? ill : 1'b0, s4};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e;
            e = exp_q.pop_front();
            check("out_vec", act_vec, e);
        end
    end

    // Driver: issue one whole instruction starting in FETCH (called at posedge+1).
    task automatic run(input logic [5:0] op, input logic z);
        int seq[$];
        opcode = op;
        zero   = z;
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 11};
            default:   seq = '{0, 1};
        endcase
        foreach (seq[i]) exp_q.push_back(exp_out(seq[i], z, 1'b1, seq.size() == 2));
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held for 3 cycles: all outputs 0.
        repeat (3) exp_q.push_back('0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run(6'b100011, 1'b0);   // lw
        run(6'b000100, 1'b1);   // beq taken
        run(6'b000100, 1'b0);   // beq not taken
        run(6'b000000, 1'b1);   // R-type (zero must not matter)
        run(6'b000010, 1'b0);   // j
        run(6'b111111, 1'b0);   // illegal
        run(6'b101011, 1'b0);   // sw
        run(6'b001000, 1'b1);   // addi

        // Reset in MEMRD of a lw aborts the instruction asynchronously.
        opcode = 6'b100011;
        zero   = 1'b0;
        exp_q.push_back(exp_out(0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(exp_out(1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(exp_out(2, 1'b0, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_memrd", act_vec, exp_out(3, 1'b0, 1'b1, 1'b0));
        reset = 1'b1;
        #1;
        check("async_abort", act_vec, '0);
        repeat (2) exp_q.push_back('0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(6'b101011, 1'b0);   // sw restarts from FETCH, no MEMWB ever seen

`ifdef MEM_WAIT_EN
        // sw with the memory stalling MEMWR for 4 cycles.
        opcode = 6'b101011;
        exp_q.push_back(exp_out(0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(exp_out(1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(exp_out(2, 1'b0, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (4) exp_q.push_back(exp_out(5, 1'b0, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        exp_q.push_back(exp_out(5, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        run(6'b000010, 1'b0);   // j, back in FETCH afterwards
`endif

        run(6'b100011, 1'b0);   // final lw

        repeat (2) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, IR/MDR/A/B/ALUOut registers.
- Decodes the opcode and issues per-state control strobes.
- Folds the branch decision into a single PC enable, PcEn = PcWrite | (PcWriteCond & zero), so the datapath needs no separate branch-AND gate.
- Sits between the instruction register opcode field and every datapath mux and write-enable.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26], stable from DECODE onward
- zero  input  1  ALU zero flag, valid combinationally in BRANCH state
- mem_ready  input  1  memory completion; used only when MEM_WAIT_EN is defined
- PcEn  output  1  PC register write enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write-register select: 0 = rt, 1 = rd
- MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unrecognised
- state  output  4  current state, for debug

Behaviour:
- State register updates on posedge clk. reset forces state = FETCH asynchronously.
- While reset is high, every output is 0, including PcEn, MemRead and IRWrite. FETCH strobes start on the first edge after reset deasserts.
- All outputs are combinational from state. PcEn additionally depends on zero in BRANCH.
- Every control signal not listed for a state is 0.
- States, encoding and actions:
  - FETCH (0): MemRead, IRWrite, ALUSrcB = 01, PCSource = 00, PcEn = 1. Next: DECODE.
  - DECODE (1): ALUSrcB = 11 (branch target into ALUOut). Next by opcode:
    - lw / sw → MEMADR
    - R-type → EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDIEX
    - any other opcode → FETCH, with illegal_op = 1
  - MEMADR (2): ALUSrcA = 1, ALUSrcB = 10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): MemRead, IorD = 1. Next: MEMWB.
  - MEMWB (4): RegWrite, MemtoReg = 1, RegDst = 0, instr_done. Next: FETCH.
  - MEMWR (5): MemWrite, IorD = 1, instr_done. Next: FETCH.
  - EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next: ALUWB.
  - ALUWB (7): RegWrite, RegDst = 1, MemtoReg = 0, instr_done. Next: FETCH.
  - BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01, PcEn = zero, instr_done. Next: FETCH.
  - ADDIEX (9): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: ADDIWB.
  - ADDIWB (10): RegWrite, RegDst = 0, MemtoReg = 0, instr_done. Next: FETCH.
  - JUMP (11): PCSource = 10, PcEn = 1, instr_done. Next: FETCH.
- Encodings 12–15 are unreachable. If entered, outputs are all 0 and the next state is FETCH.
- Cycles per instruction (FETCH through the instr_done cycle):
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
  - illegal opcode = 2 (no instr_done)
- opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset asserted mid-instruction aborts it immediately: no further strobes, and no instr_done for the aborted instruction.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - FETCH, MEMRD and MEMWR hold their state and keep all strobes asserted until mem_ready = 1. They advance on the edge where mem_ready = 1.
  - In FETCH, PcEn and IRWrite assert only in the mem_ready = 1 cycle.
  - In MEMWR, instr_done asserts only in the mem_ready = 1 cycle.
- When undefined: mem_ready is ignored and each memory state lasts exactly one cycle.

Test Plan:
- Reset held high for 3 cycles, then released → all outputs 0 during reset. First cycle after release: state = 0, MemRead = 1, IRWrite = 1, PcEn = 1.
- opcode = 100011 (lw) → state sequence 0, 1, 2, 3, 4, 0. In state 4: RegWrite = 1, MemtoReg = 1, instr_done = 1. Total 5 cycles.
- opcode = 000100 (beq), once with zero = 1 and once with zero = 0 → in state 8, PcEn = 1 and PCSource = 01 for zero = 1; PcEn = 0 for zero = 0. Both cases return to state 0 after 3 cycles.
- opcode = 000000, then 000010, then 111111 → R-type: RegDst = 1 and RegWrite = 1 in state 7. Jump: PCSource = 10 and PcEn = 1 in state 11. 111111: illegal_op pulse in state 1, then state 0, with no instr_done.
- reset asserted while in state 3 (lw) → state = 0 and all outputs 0 asynchronously, before the next clock edge. No MEMWB cycle occurs.
- With MEM_WAIT_EN defined and mem_ready = 0 for 4 cycles during sw MEMWR → state stays 5 with MemWrite = 1. instr_done pulses only in the mem_ready = 1 cycle, then state = 0.
